dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/mips_pkg.sv | 6 +
 rtl/dmem_array.sv | 21 ++
 rtl/dmem_responder.sv | 76 +++++++
 tb/tb_dmem_responder.sv | 128 ++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared widths and responder state type for the data-memory slice
package mips_pkg;
  localparam int WORD_W = 32;
  localparam int BE_W = 4;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word memory, synchronous per-byte write, combinational read
// Ports: clk; we/be/addr/wdata write side; rdata returns the word at addr.
module dmem_array
  import mips_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    for (int i = 0; i < BE_W; i++)
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory responder with fixed access latency
// Ports: clk, rst (sync active-high); req_valid/req_ready/req_we/req_addr/req_wdata/req_be
// request channel; resp_valid/resp_ready/resp_rdata/resp_err response channel.
// Optional DMEM_BYTE_STROBE_EN: stores honour req_be; otherwise stores write whole words.
module dmem_responder
  import mips_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);
  localparam int AW = $clog2(DEPTH);
  state_t state, state_nx;
  logic [3:0] cnt;
  logic lat_we;
  logic [WORD_W-1:0] lat_addr, lat_wdata, rdata;
  logic [BE_W-1:0] lat_be, wr_be;
  logic err, exec, accept, mem_we;
  assign accept = state == IDLE && req_valid;
  assign exec = state == BUSY && cnt == 4'd1;
  assign err = |lat_addr[1:0] || |lat_addr[WORD_W-1:AW+2];
`ifdef DMEM_BYTE_STROBE_EN
  assign wr_be = lat_be;
`else
  assign wr_be = '1;
`endif
  // a reset landing on the execute edge must still discard the store
  assign mem_we = exec && lat_we && !err && !rst;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = accept ? BUSY : exec ? RESP : (state == RESP && resp_ready) ? IDLE : state;
  always_comb begin
    req_ready = state == IDLE;
    resp_valid = state == RESP;
  end
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else begin
      if (accept) begin
        cnt <= 4'(WAIT_CYCLES);
        lat_we <= req_we;
        lat_addr <= req_addr;
        lat_wdata <= req_wdata;
        lat_be <= req_be;
      end else if (state == BUSY) cnt <= cnt - 4'd1;
      if (exec) begin
        resp_err <= err;
        resp_rdata <= (err || lat_we) ? '0 : rdata;
      end
    end
  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk(clk),
    .we(mem_we),
    .be(wr_be),
    .addr(lat_addr[AW+1:2]),
    .wdata(lat_wdata),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector bench for dmem_responder (DEPTH=256, WAIT_CYCLES=2)
module tb_dmem_responder;
  localparam int W = 2;
`ifdef DMEM_BYTE_STROBE_EN
  localparam logic [31:0] STRB_EXP = 32'hFF22FF44;
  localparam logic [31:0] NOOP_EXP = 32'hFF22FF44;
`else
  localparam logic [31:0] STRB_EXP = 32'h11223344;
  localparam logic [31:0] NOOP_EXP = 32'h55555555;
`endif
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, req_we = 0, resp_valid, resp_ready = 0, resp_err;
  logic [31:0] req_addr = 0, req_wdata = 0, resp_rdata;
  logic [3:0] req_be = 0;
  int n_pass = 0, n_total = 0;
  vec_t vecs[$];
  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rd, output logic er,
                        output int lat);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk); #1;
    req_valid = 0; req_we = ~we; req_addr = 32'h4; req_wdata = ~wdata; req_be = ~be;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata; er = resp_err;
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
    check("resp_valid_drop", 32'(resp_valid), 32'd0);
  endtask
  initial begin
    logic [31:0] rd;
    logic er;
    int lat;
    vecs.push_back('{1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h010, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h020, 32'h12345678, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 32'h000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h013, 32'h0,        4'hF, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 32'h402, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 32'h000, 32'h0,        4'hF, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{1'b0, 32'h400, 32'h0,        4'hF, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 32'h3FC, 32'h0BADF00D, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h3FC, 32'h0,        4'hF, 32'h0BADF00D, 1'b0});
    vecs.push_back('{1'b0, 32'h020, 32'h0,        4'hF, 32'h12345678, 1'b0});
    vecs.push_back('{1'b1, 32'h000, 32'h11223344, 4'h5, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h000, 32'h0,        4'hF, STRB_EXP, 1'b0});
    vecs.push_back('{1'b1, 32'h000, 32'h55555555, 4'h0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h000, 32'h0,        4'hF, NOOP_EXP, 1'b0});
    req_valid = 1; req_we = 1; req_addr = 32'h10;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 0;
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_rdata", resp_rdata, 32'd0);
    check("reset_resp_err", 32'(resp_err), 32'd0);
    rst = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(W));
    end
    // backpressure: hold the load response while a competing store is offered
    req_valid = 1; req_we = 0; req_addr = 32'h10; req_be = 4'hF;
    @(posedge clk); #1;
    req_we = 1; req_wdata = 32'h0;
    repeat (W) begin @(posedge clk); #1; end
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d_resp_valid", c), 32'(resp_valid), 32'd1);
      check($sformatf("bp%0d_rdata", c), resp_rdata, 32'hDEADBEEF);
      check($sformatf("bp%0d_err", c), 32'(resp_err), 32'd0);
      check($sformatf("bp%0d_req_ready", c), 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 0; resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
    check("bp_resp_valid_drop", 32'(resp_valid), 32'd0);
    access(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    check("bp_mem_unchanged", rd, 32'hDEADBEEF);
    // reset landing on the would-be execute edge of a store
    req_valid = 1; req_we = 1; req_addr = 32'h20; req_wdata = 32'hA5A5A5A5; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("abort_resp_err", 32'(resp_err), 32'd0);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("abort%0d_resp_valid", c), 32'(resp_valid), 32'd0);
      @(posedge clk); #1;
    end
    access(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    check("abort_prior_value", rd, 32'h12345678);
    check("abort_load_err", 32'(er), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
